spi_telemetry_port: RTL
=======================

# spi_telemetry_port

Parametrised SPI slave register port that exposes NUM_CH telemetry channels (pose, wheel RPM, distances, IMU, behaviour, etc.) to an external host and receives one control byte back. It generalises the fixed-map SPI interface: channel count and channel width are parameters, multi-byte channel reads are snapshot-coherent, reads auto-increment with wrap, and framing errors are detected. It sits between the board SPI pins and the robot datapath, in the 50 MHz domain.

## Interface
- NUM_CH, 16, number of telemetry channels (1..127)
- CH_WIDTH, 17, bits per channel (1..32); transmitted as BYTES_PER_CH = ceil(CH_WIDTH/8) bytes
- CTRL_RESET, 8'h00, reset value of control register
- SPI_TELEMETRY_PORT_CLOCK_50  in  1  system clock, 50 MHz
- SPI_TELEMETRY_PORT_RESET_InHigh  in  1  asynchronous reset, active-high
- SPI_TELEMETRY_PORT_SS_InLow  in  1  slave select, active-low, asynchronous to clock
- SPI_TELEMETRY_PORT_SCK_In  in  1  SPI clock, mode 0, at most CLOCK_50/8
- SPI_TELEMETRY_PORT_MOSI_In  in  1  host-to-slave data, MSB first
- SPI_TELEMETRY_PORT_CH_InBus  in  NUM_CH*CH_WIDTH  flattened channels; channel k at bits [k*CH_WIDTH +: CH_WIDTH]
- SPI_TELEMETRY_PORT_MISO_Out  out  1  slave-to-host data
- SPI_TELEMETRY_PORT_CTRL_OutBus  out  8  control register ([2:0] way select, [3] stop_n, [4] begin_n, [7:5] spare)
- SPI_TELEMETRY_PORT_CTRLSTB_Out  out  1  one-cycle pulse when CTRL_OutBus is updated
- SPI_TELEMETRY_PORT_FRAMEERR_Out  out  1  one-cycle pulse on a framing error

## Operation
- Frame = SS low interval. First byte is the command: bit7 = 1 write, 0 read; bits[6:0] = address.
- Read (bit7 = 0, addr < NUM_CH): on command-byte completion, snapshot all of CH_InBus into a holding register in the same cycle. Then stream channel addr, MSB byte first, zero-extended to BYTES_PER_CH*8 bits, then addr+1, and so on. Channel index wraps NUM_CH-1 -> 0. Stream continues until SS rises. The snapshot is taken only once per frame.
- Read with addr >= NUM_CH: every data byte is 8'hFF and FRAMEERR pulses once at command decode.
- Write (bit7 = 1, addr = 0): the next complete byte loads CTRL_OutBus, and CTRLSTB pulses in the same cycle. Further bytes in that frame are ignored and MISO returns 8'h00. Write with addr != 0: data is ignored and FRAMEERR pulses at command decode.
- MISO returns 8'h00 during the command byte.
- States:
  - IDLE: SS high.
  - CMD: SS falls.
  - After 8 bits in CMD, go to RD, WR or SKIP according to decode.
  - WR: after 1 byte, go to SKIP.
  - Any state: SS rises, go to IDLE.
- SS rising while the bit counter is nonzero (partial byte) is a framing error: FRAMEERR pulses, the partial byte is discarded, and CTRL is unchanged.
- Reset outputs: MISO 0, CTRL_OutBus CTRL_RESET, CTRLSTB 0, FRAMEERR 0, state IDLE, bit counter 0.
- Reset asserted mid-frame aborts the frame. After release, the block waits for SS high before accepting a new frame; a frame already in progress is ignored.

## Timing
- SS, SCK and MOSI each pass through a 2-FF synchroniser, with edge detect on the synchronised SCK.
- MOSI is sampled on the SCK rising edge. MISO changes on the SCK falling edge; the first bit of a byte is driven within 4 clocks of SS falling (command byte) or of the preceding byte's last rising edge (data bytes).
- Byte-complete to next transmit byte loaded: at most 2 clocks. This requires SCK <= CLOCK_50/8.
- CTRL_OutBus updates 3–4 clocks after the 8th rising SCK edge of the write data byte.
- SS rise to IDLE: 3 clocks.
- Width rules:
  - BYTES_PER_CH is a localparam.
  - The byte index within a channel counts 0..BYTES_PER_CH-1.
  - The channel pointer is $clog2(NUM_CH) bits (minimum 1) and wraps explicitly; it does not rely on a power of 2.

## Structure
- Shared package spi_telemetry_pkg holds:
  - the state enum (IDLE, CMD, RD, WR, SKIP)
  - CMD_WRITE_BIT = 7
  - CTRL_ADDR = 7'd0
  - FILL_BYTE = 8'hFF
  - IDLE_BYTE = 8'h00
- Sub-module spi_byte_shifter contains the synchronisers, edge detect, bit counter and 8-bit RX/TX shift registers. It emits byte_valid/rx_byte, accepts tx_byte with tx_load, and flags partial-byte aborts.
- The top level holds the frame FSM, the snapshot register, the channel/byte pointers and the CTRL register.

## Test plan
- Read ch2 with NUM_CH=16, CH_WIDTH=17 and ch2 = 17'h1ABCD. Command 8'h02, then 3 dummy bytes -> MISO returns 00, 01, AB, CD. Changing CH_InBus mid-frame does not alter the bytes.
- Read wrap: command 8'h0F, then 6 dummy bytes -> ch15 (3 bytes) followed by ch0 (3 bytes).
- Write: command 8'h80, then 8'h1A -> CTRL_OutBus = 8'h1A with one CTRLSTB pulse. A third byte 8'hFF leaves CTRL at 8'h1A.
- Error cases, each giving one FRAMEERR pulse:
  - Command 8'h7F -> data bytes FF.
  - Command 8'h85 -> CTRL unchanged.
  - SS raised after 5 bits of the write data byte -> CTRL unchanged.
- Reset asserted mid-read-stream -> all outputs at their reset values, CTRL = CTRL_RESET. The next complete frame (8'h00 + 3 bytes) returns correct ch0 data.
- Back-to-back frames with 1 SCK period of SS high between them -> each frame decodes independently, and the second frame re-snapshots.

Source files
------------

// File: rtl/spi_telemetry_pkg.sv
// Shared types and constants for the SPI telemetry register port.
package spi_telemetry_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RD,
        WR,
        SKIP
    } spiState_e;

    localparam int unsigned CMD_WRITE_BIT = 7;
    localparam logic [6:0]  CTRL_ADDR     = 7'd0;
    localparam logic [7:0]  FILL_BYTE     = 8'hFF;
    localparam logic [7:0]  IDLE_BYTE     = 8'h00;

    function automatic int unsigned bytesFor(input int unsigned bits);
        return (bits + 7) / 8;
    endfunction

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int unsigned ptrBits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_telemetry_port_if.sv
// Pin-level bundle between the SPI host side and the telemetry port.
interface spi_telemetry_port_if #(
    parameter int unsigned NUM_CH   = 16,
    parameter int unsigned CH_WIDTH = 17
);
    logic                         SPI_TELEMETRY_PORT_SS_InLow;
    logic                         SPI_TELEMETRY_PORT_SCK_In;
    logic                         SPI_TELEMETRY_PORT_MOSI_In;
    logic [NUM_CH*CH_WIDTH-1:0]   SPI_TELEMETRY_PORT_CH_InBus;
    logic                         SPI_TELEMETRY_PORT_MISO_Out;
    logic [7:0]                   SPI_TELEMETRY_PORT_CTRL_OutBus;
    logic                         SPI_TELEMETRY_PORT_CTRLSTB_Out;
    logic                         SPI_TELEMETRY_PORT_FRAMEERR_Out;

    modport master (
        output SPI_TELEMETRY_PORT_SS_InLow, SPI_TELEMETRY_PORT_SCK_In,
               SPI_TELEMETRY_PORT_MOSI_In, SPI_TELEMETRY_PORT_CH_InBus,
        input  SPI_TELEMETRY_PORT_MISO_Out, SPI_TELEMETRY_PORT_CTRL_OutBus,
               SPI_TELEMETRY_PORT_CTRLSTB_Out, SPI_TELEMETRY_PORT_FRAMEERR_Out
    );

    modport slave (
        input  SPI_TELEMETRY_PORT_SS_InLow, SPI_TELEMETRY_PORT_SCK_In,
               SPI_TELEMETRY_PORT_MOSI_In, SPI_TELEMETRY_PORT_CH_InBus,
        output SPI_TELEMETRY_PORT_MISO_Out, SPI_TELEMETRY_PORT_CTRL_OutBus,
               SPI_TELEMETRY_PORT_CTRLSTB_Out, SPI_TELEMETRY_PORT_FRAMEERR_Out
    );
endinterface

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte engine: input synchronisers, SCK edge detect, bit counter,
// RX/TX shift registers and partial-byte abort detection.
module spi_byte_shifter
    import spi_telemetry_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ssN,
    input  logic       sck,
    input  logic       mosi,
    input  logic       txLoad,
    input  logic [7:0] txByte,
    output logic       miso,
    output logic       byteValid,
    output logic [7:0] rxByte,
    output logic       abort,
    output logic       frameActive_c
);

    logic [1:0] ssSync;
    logic [1:0] sckSync;
    logic [1:0] mosiSync;
    logic       sckPrev;
    logic       armed;
    logic [2:0] bitCnt;
    logic [6:0] rxShift;
    logic [7:0] txShift;

    logic ssS;
    logic sckS;
    logic mosiS;
    logic sckRise;
    logic sckFall;

    assign ssS     = ssSync[1];
    assign sckS    = sckSync[1];
    assign mosiS   = mosiSync[1];
    assign sckRise = sckS & ~sckPrev;
    assign sckFall = ~sckS & sckPrev;

    // armed is cleared by reset and only set once SS is seen high, so a frame
    // already in progress at reset release is ignored.
    assign frameActive_c = armed & ~ssS;
    assign miso          = txShift[7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ssSync    <= 2'b00;
            sckSync   <= 2'b00;
            mosiSync  <= 2'b00;
            sckPrev   <= 1'b0;
            armed     <= 1'b0;
            bitCnt    <= 3'd0;
            rxShift   <= 7'd0;
            txShift   <= IDLE_BYTE;
            byteValid <= 1'b0;
            rxByte    <= 8'd0;
            abort     <= 1'b0;
        end else begin
            ssSync    <= {ssSync[0], ssN};
            sckSync   <= {sckSync[0], sck};
            mosiSync  <= {mosiSync[0], mosi};
            sckPrev   <= sckS;
            byteValid <= 1'b0;
            abort     <= 1'b0;
            if (ssS) begin
                armed   <= 1'b1;
                abort   <= (bitCnt != 3'd0);
                bitCnt  <= 3'd0;
                txShift <= IDLE_BYTE;
            end else if (armed) begin
                if (sckRise) begin
                    rxShift <= {rxShift[5:0], mosiS};
                    bitCnt  <= bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        byteValid <= 1'b1;
                        rxByte    <= {rxShift, mosiS};
                    end
                // The falling edge after bit 8 must not shift out the freshly loaded MSB.
                end else if (sckFall && (bitCnt != 3'd0)) begin
                    txShift <= {txShift[6:0], 1'b0};
                end
                if (txLoad) begin
                    txShift <= txByte;
                end
            end
        end
    end

endmodule

// File: rtl/spi_telemetry_port.sv
// SPI slave register port: frame FSM, coherent channel snapshot, auto-incrementing
// read pointer with wrap, and the host-written control register.
module spi_telemetry_port
    import spi_telemetry_pkg::*;
#(
    parameter int unsigned NUM_CH     = 16,
    parameter int unsigned CH_WIDTH   = 17,
    parameter logic [7:0]  CTRL_RESET = 8'h00
) (
    input  logic                 SPI_TELEMETRY_PORT_CLOCK_50,
    input  logic                 SPI_TELEMETRY_PORT_RESET_InHigh,
    spi_telemetry_port_if.slave  bus
);

    localparam int unsigned BYTES_PER_CH = bytesFor(CH_WIDTH);
    localparam int unsigned PTR_W        = ptrBits(NUM_CH);
    localparam int unsigned IDX_W        = ptrBits(BYTES_PER_CH);
    localparam int unsigned WIDE_W       = BYTES_PER_CH * 8;

    logic clk;
    logic rst;
    assign clk = SPI_TELEMETRY_PORT_CLOCK_50;
    assign rst = SPI_TELEMETRY_PORT_RESET_InHigh;

    spiState_e state;
    spiState_e stateNext;

    logic [CH_WIDTH-1:0] chIn [NUM_CH];
    logic [CH_WIDTH-1:0] snap [NUM_CH];
    logic [PTR_W-1:0]    chPtr;
    logic [IDX_W-1:0]    byteIdx;
    logic [7:0]          ctrlReg;
    logic                ctrlStb;
    logic                frameErr;
    logic                txLoad;
    logic [7:0]          txByte;
    logic                skipFill;

    logic                shMiso;
    logic                shByteValid;
    logic [7:0]          shRxByte;
    logic                shAbort;
    logic                frameActive_c;

    logic [PTR_W-1:0]    cmdPtr;
    logic [PTR_W-1:0]    selPtr;
    logic [IDX_W-1:0]    selIdx;
    logic [CH_WIDTH-1:0] selWord;
    logic [PTR_W-1:0]    nextPtr;
    logic [IDX_W-1:0]    nextIdx;

    logic                snapEn;
    logic                ptrUpd;
    logic                ctrlEn;
    logic                errNext;
    logic                txLoadNext;
    logic [7:0]          txByteNext;
    logic                skipFillNext;

    spi_byte_shifter uShifter (
        .clk          (clk),
        .rst          (rst),
        .ssN          (bus.SPI_TELEMETRY_PORT_SS_InLow),
        .sck          (bus.SPI_TELEMETRY_PORT_SCK_In),
        .mosi         (bus.SPI_TELEMETRY_PORT_MOSI_In),
        .txLoad       (txLoad),
        .txByte       (txByte),
        .miso         (shMiso),
        .byteValid    (shByteValid),
        .rxByte       (shRxByte),
        .abort        (shAbort),
        .frameActive_c(frameActive_c)
    );

    assign bus.SPI_TELEMETRY_PORT_MISO_Out     = shMiso;
    assign bus.SPI_TELEMETRY_PORT_CTRL_OutBus  = ctrlReg;
    assign bus.SPI_TELEMETRY_PORT_CTRLSTB_Out  = ctrlStb;
    assign bus.SPI_TELEMETRY_PORT_FRAMEERR_Out = frameErr;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            chIn[k] = bus.SPI_TELEMETRY_PORT_CH_InBus[k*CH_WIDTH +: CH_WIDTH];
        end
    end

    // Selects channel byte idx, MSB byte first, from the zero-extended word.
    function automatic logic [7:0] pickByte(input logic [CH_WIDTH-1:0] word,
                                            input logic [IDX_W-1:0] idx);
        logic [WIDE_W-1:0] wide;
        wide = WIDE_W'(word);
        return 8'(wide >> (8 * (BYTES_PER_CH - 1 - 32'(idx))));
    endfunction

    // At command decode the first byte comes straight from the live bus, which is
    // what the snapshot captures in that same cycle; afterwards from the snapshot.
    always_comb begin
        cmdPtr  = PTR_W'(shRxByte[6:0]);
        selPtr  = (state == CMD) ? cmdPtr : chPtr;
        selIdx  = (state == CMD) ? '0 : byteIdx;
        selWord = (state == CMD) ? chIn[cmdPtr] : snap[chPtr];
        if (selIdx == IDX_W'(BYTES_PER_CH - 1)) begin
            nextIdx = '0;
            nextPtr = (selPtr == PTR_W'(NUM_CH - 1)) ? '0 : selPtr + PTR_W'(1);
        end else begin
            nextIdx = selIdx + IDX_W'(1);
            nextPtr = selPtr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext    = state;
        snapEn       = 1'b0;
        ptrUpd       = 1'b0;
        ctrlEn       = 1'b0;
        errNext      = shAbort;
        txLoadNext   = 1'b0;
        txByteNext   = IDLE_BYTE;
        skipFillNext = skipFill;
        if (!frameActive_c) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: stateNext = CMD;
                CMD: begin
                    if (shByteValid) begin
                        txLoadNext = 1'b1;
                        if (shRxByte[CMD_WRITE_BIT]) begin
                            skipFillNext = 1'b0;
                            if (shRxByte[6:0] == CTRL_ADDR) begin
                                stateNext = WR;
                            end else begin
                                stateNext = SKIP;
                                errNext   = 1'b1;
                            end
                        end else if (shRxByte[6:0] < 7'(NUM_CH)) begin
                            stateNext  = RD;
                            snapEn     = 1'b1;
                            ptrUpd     = 1'b1;
                            txByteNext = pickByte(selWord, selIdx);
                        end else begin
                            stateNext    = SKIP;
                            errNext      = 1'b1;
                            skipFillNext = 1'b1;
                            txByteNext   = FILL_BYTE;
                        end
                    end
                end
                RD: begin
                    if (shByteValid) begin
                        txLoadNext = 1'b1;
                        ptrUpd     = 1'b1;
                        txByteNext = pickByte(selWord, selIdx);
                    end
                end
                WR: begin
                    if (shByteValid) begin
                        ctrlEn       = 1'b1;
                        stateNext    = SKIP;
                        txLoadNext   = 1'b1;
                        skipFillNext = 1'b0;
                    end
                end
                SKIP: begin
                    if (shByteValid) begin
                        txLoadNext = 1'b1;
                        txByteNext = skipFill ? FILL_BYTE : IDLE_BYTE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chPtr    <= '0;
            byteIdx  <= '0;
            ctrlReg  <= CTRL_RESET;
            ctrlStb  <= 1'b0;
            frameErr <= 1'b0;
            txLoad   <= 1'b0;
            txByte   <= IDLE_BYTE;
            skipFill <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                snap[k] <= '0;
            end
        end else begin
            ctrlStb  <= ctrlEn;
            frameErr <= errNext;
            txLoad   <= txLoadNext;
            txByte   <= txByteNext;
            skipFill <= skipFillNext;
            if (ctrlEn) begin
                ctrlReg <= shRxByte;
            end
            if (ptrUpd) begin
                chPtr   <= nextPtr;
                byteIdx <= nextIdx;
            end
            if (snapEn) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    snap[k] <= chIn[k];
                end
            end
        end
    end

endmodule
